// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX-side stages.
// ALU select codes, ALU_op classes, opcode/funct values, operand routes.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [1:0] AOP_MEM = 2'b00;
  localparam logic [1:0] AOP_BR  = 2'b01;
  localparam logic [1:0] AOP_R   = 2'b10;
  localparam logic [1:0] AOP_I   = 2'b11;

  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  typedef enum logic {
    OP1_RS,
    OP1_RT
  } op1_src_e;

  typedef enum logic [1:0] {
    OP2_RT,
    OP2_RS,
    OP2_IMM,
    OP2_RS5
  } op2_src_e;

endpackage

// File: rtl/ex_forward_mux.sv
// Per-operand bypass select: EX/MEM, then MEM/WB, then RF value.
// Register 0 is hardwired and is never bypassed.
module ex_forward_mux #(
  parameter int DWL = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] i_addr,
  input  logic [DWL-1:0] i_rf_data,
  input  logic [RAW-1:0] i_exmem_rd,
  input  logic           i_exmem_regwr,
  input  logic [DWL-1:0] i_exmem_result,
  input  logic [RAW-1:0] i_memwb_rd,
  input  logic           i_memwb_regwr,
  input  logic [DWL-1:0] i_memwb_result,
  output logic [DWL-1:0] o_data
);

  logic w_nz;
  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_nz = |i_addr;
  assign w_hit_exmem = w_nz && i_exmem_regwr
                    && (i_exmem_rd == i_addr);
  assign w_hit_memwb = w_nz && i_memwb_regwr
                    && (i_memwb_rd == i_addr);

  // Younger producer (EX/MEM) takes priority.
  always_comb begin
    o_data = i_rf_data;
    if (w_hit_exmem)
      o_data = i_exmem_result;
    else if (w_hit_memwb)
      o_data = i_memwb_result;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU_sel decode and operand forwarding.
// Routing is decoded in ID; bypass is applied after the register.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DWL = 32,
  parameter int RAW = 5
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic           stall,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [1:0]     id_alu_op,
  input  logic [5:0]     id_opcode,
  input  logic [5:0]     id_funct,
  input  logic [4:0]     id_shamt,
  input  logic [15:0]    id_imm16,
  input  logic [RAW-1:0] id_rs_addr,
  input  logic [RAW-1:0] id_rt_addr,
  input  logic [DWL-1:0] id_rs_data,
  input  logic [DWL-1:0] id_rt_data,
  input  logic [RAW-1:0] id_dest,
  input  logic [3:0]     id_ctl,
  input  logic [RAW-1:0] exmem_rd,
  input  logic           exmem_regwr,
  input  logic [DWL-1:0] exmem_result,
  input  logic [RAW-1:0] memwb_rd,
  input  logic           memwb_regwr,
  input  logic [DWL-1:0] memwb_result,
  output logic [3:0]     ALU_sel,
  output logic [DWL-1:0] Din1,
  output logic [DWL-1:0] Din2,
  output logic [DWL-1:0] ex_store_data,
  output logic [RAW-1:0] ex_dest,
  output logic [3:0]     ex_ctl,
  output logic           ex_valid,
  output logic           ex_illegal
);

  logic [3:0]     w_sel;
  op1_src_e       w_op1;
  op2_src_e       w_op2;
  logic [DWL-1:0] w_imm;
  logic           w_ill;
  logic [DWL-1:0] w_sext;
  logic [DWL-1:0] w_zext;
  logic [DWL-1:0] w_shamt;
  logic           w_bubble;

  logic [3:0]     r_sel;
  op1_src_e       r_op1;
  op2_src_e       r_op2;
  logic [DWL-1:0] r_imm;
  logic           r_ill;
  logic           r_valid;
  logic [3:0]     r_ctl;
  logic [RAW-1:0] r_dest;
  logic [RAW-1:0] r_rs_addr;
  logic [RAW-1:0] r_rt_addr;
  logic [DWL-1:0] r_rs_data;
  logic [DWL-1:0] r_rt_data;

  logic [DWL-1:0] w_rs_fwd;
  logic [DWL-1:0] w_rt_fwd;

  assign w_sext  = {{(DWL-16){id_imm16[15]}}, id_imm16};
  assign w_zext  = {{(DWL-16){1'b0}}, id_imm16};
  assign w_shamt = {{(DWL-5){1'b0}}, id_shamt};

  // Translate ALU_op/opcode/funct into ALU_sel and operand routes.
  always_comb begin
    w_sel = ALU_ADD;
    w_op1 = OP1_RS;
    w_op2 = OP2_IMM;
    w_imm = w_sext;
    w_ill = 1'b0;
    unique case (id_alu_op)
      AOP_MEM: begin
        w_sel = ALU_ADD;
      end
      AOP_BR: begin
        w_sel = ALU_SUB;
        w_op1 = OP1_RT;
        w_op2 = OP2_RS;
      end
      AOP_I: begin
        unique case (1'b1)
          (id_opcode == OPC_ANDI): begin
            w_sel = ALU_AND;
            w_imm = w_zext;
          end
          (id_opcode == OPC_ORI): begin
            w_sel = ALU_OR;
            w_imm = w_zext;
          end
          (id_opcode == OPC_XORI): begin
            w_sel = ALU_XOR;
            w_imm = w_zext;
          end
          (id_opcode == OPC_ADDI),
          (id_opcode == OPC_ADDIU): begin
            w_sel = ALU_ADD;
          end
          default: begin
            w_ill = 1'b1;
          end
        endcase
      end
      default: begin
        w_op2 = OP2_RT;
        unique case (1'b1)
          (id_funct == FN_ADD),
          (id_funct == FN_ADDU): begin
            w_sel = ALU_ADD;
          end
          (id_funct == FN_SUB),
          (id_funct == FN_SUBU): begin
            w_sel = ALU_SUB;
            w_op1 = OP1_RT;
            w_op2 = OP2_RS;
          end
          (id_funct == FN_AND): w_sel = ALU_AND;
          (id_funct == FN_OR):  w_sel = ALU_OR;
          (id_funct == FN_XOR): w_sel = ALU_XOR;
          (id_funct == FN_SLL): begin
            w_sel = ALU_SLL;
            w_op1 = OP1_RT;
            w_op2 = OP2_IMM;
            w_imm = w_shamt;
          end
          (id_funct == FN_SRL): begin
            w_sel = ALU_SRL;
            w_op1 = OP1_RT;
            w_op2 = OP2_IMM;
            w_imm = w_shamt;
          end
          (id_funct == FN_SRA): begin
            w_sel = ALU_SRA;
            w_op1 = OP1_RT;
            w_op2 = OP2_IMM;
            w_imm = w_shamt;
          end
          (id_funct == FN_SLLV): begin
            w_sel = ALU_SLL;
            w_op1 = OP1_RT;
            w_op2 = OP2_RS5;
          end
          (id_funct == FN_SRLV): begin
            w_sel = ALU_SRL;
            w_op1 = OP1_RT;
            w_op2 = OP2_RS5;
          end
          (id_funct == FN_SRAV): begin
            w_sel = ALU_SRA;
            w_op1 = OP1_RT;
            w_op2 = OP2_RS5;
          end
          default: begin
            w_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  // An unstalled load of a non-instruction becomes a bubble.
  assign w_bubble = flush || (!stall && !id_valid);

  // ID/EX register: flush beats stall beats load.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sel     <= 4'b0000;
      r_op1     <= OP1_RS;
      r_op2     <= OP2_RT;
      r_imm     <= '0;
      r_ill     <= 1'b0;
      r_valid   <= 1'b0;
      r_ctl     <= 4'b0000;
      r_dest    <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else if (w_bubble) begin
      r_sel     <= ALU_ADD;
      r_op1     <= OP1_RS;
      r_op2     <= OP2_IMM;
      r_imm     <= '0;
      r_ill     <= 1'b0;
      r_valid   <= 1'b0;
      r_ctl     <= 4'b0000;
      r_dest    <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else if (!stall) begin
      r_sel     <= w_sel;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_imm     <= w_imm;
      r_ill     <= w_ill;
      r_valid   <= 1'b1;
      r_ctl     <= id_ctl;
      r_dest    <= id_dest;
      r_rs_addr <= id_rs_addr;
      r_rt_addr <= id_rt_addr;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
    end
  end

  ex_forward_mux #(.DWL(DWL), .RAW(RAW)) u_fwd_rs (
    .i_addr         (r_rs_addr),
    .i_rf_data      (r_rs_data),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_regwr  (exmem_regwr),
    .i_exmem_result (exmem_result),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_regwr  (memwb_regwr),
    .i_memwb_result (memwb_result),
    .o_data         (w_rs_fwd)
  );

  ex_forward_mux #(.DWL(DWL), .RAW(RAW)) u_fwd_rt (
    .i_addr         (r_rt_addr),
    .i_rf_data      (r_rt_data),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_regwr  (exmem_regwr),
    .i_exmem_result (exmem_result),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_regwr  (memwb_regwr),
    .i_memwb_result (memwb_result),
    .o_data         (w_rt_fwd)
  );

  // Route bypassed values onto the ALU operand buses.
  always_comb begin
    Din1 = w_rs_fwd;
    if (r_op1 == OP1_RT)
      Din1 = w_rt_fwd;
    Din2 = w_rt_fwd;
    unique case (r_op2)
      OP2_RT:  Din2 = w_rt_fwd;
      OP2_RS:  Din2 = w_rs_fwd;
      OP2_IMM: Din2 = r_imm;
      default: Din2 = {{(DWL-5){1'b0}}, w_rs_fwd[4:0]};
    endcase
  end

  assign ex_store_data = w_rt_fwd;
  assign ALU_sel       = r_sel;
  assign ex_dest       = r_dest;
  assign ex_ctl        = r_ctl;
  assign ex_valid      = r_valid;
  assign ex_illegal    = r_ill;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [3:0]  ctl;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [1:0]  id_alu_op = '0;
  logic [5:0]  id_opcode = '0;
  logic [5:0]  id_funct = '0;
  logic [4:0]  id_shamt = '0;
  logic [15:0] id_imm16 = '0;
  logic [4:0]  id_rs_addr = '0;
  logic [4:0]  id_rt_addr = '0;
  logic [31:0] id_rs_data = '0;
  logic [31:0] id_rt_data = '0;
  logic [4:0]  id_dest = '0;
  logic [3:0]  id_ctl = '0;
  logic [4:0]  exmem_rd = '0;
  logic        exmem_regwr = 1'b0;
  logic [31:0] exmem_result = '0;
  logic [4:0]  memwb_rd = '0;
  logic        memwb_regwr = 1'b0;
  logic [31:0] memwb_result = '0;
  logic [3:0]  ALU_sel;
  logic [31:0] Din1;
  logic [31:0] Din2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_ctl;
  logic        ex_valid;
  logic        ex_illegal;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t last_exp;

  logic [4:0]  nx_erd = '0;
  logic        nx_ewr = 1'b0;
  logic [31:0] nx_eres = '0;
  logic [4:0]  nx_mrd = '0;
  logic        nx_mwr = 1'b0;
  logic [31:0] nx_mres = '0;

  id_ex_operand_stage #(.DWL(32), .RAW(5)) dut (
    .CLK(CLK), .RST_n(RST_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_shamt(id_shamt), .id_imm16(id_imm16),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_dest(id_dest), .id_ctl(id_ctl),
    .exmem_rd(exmem_rd), .exmem_regwr(exmem_regwr),
    .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwr(memwb_regwr),
    .memwb_result(memwb_result),
    .ALU_sel(ALU_sel), .Din1(Din1), .Din2(Din2),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_ctl(ex_ctl), .ex_valid(ex_valid),
    .ex_illegal(ex_illegal)
  );

  always #5 CLK = ~CLK;

  // Monitor: every valid EX slot must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    exp_t g;
    if (RST_n && ex_valid) begin
      g = '{ALU_sel, Din1, Din2, ex_store_data,
            ex_dest, ex_ctl, ex_illegal};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%h", g);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL ex_slot got=%h want=%h", g, e);
        end
      end
    end
  end

  task automatic fwd(input logic [4:0] erd, input logic ewr,
                     input logic [31:0] eres,
                     input logic [4:0] mrd, input logic mwr,
                     input logic [31:0] mres);
    nx_erd = erd; nx_ewr = ewr; nx_eres = eres;
    nx_mrd = mrd; nx_mwr = mwr; nx_mres = mres;
  endtask

  task automatic issue(
    input logic [1:0] op, input logic [5:0] opc,
    input logic [5:0] fn, input logic [4:0] sh,
    input logic [15:0] imm,
    input logic [4:0] rs, input logic [31:0] rsd,
    input logic [4:0] rt, input logic [31:0] rtd,
    input logic [4:0] dst, input logic [3:0] ctl,
    input logic [3:0] esel, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] est,
    input logic eill);
    id_valid = 1'b1; id_alu_op = op; id_opcode = opc;
    id_funct = fn; id_shamt = sh; id_imm16 = imm;
    id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd;
    id_dest = dst; id_ctl = ctl;
    @(posedge CLK); #1;
    exmem_rd = nx_erd; exmem_regwr = nx_ewr;
    exmem_result = nx_eres;
    memwb_rd = nx_mrd; memwb_regwr = nx_mwr;
    memwb_result = nx_mres;
    fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    last_exp = '{esel, e1, e2, est, dst, ctl, eill};
    q.push_back(last_exp);
  endtask

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_bubble(input string name);
    check(name,
      {ex_valid, ex_ctl, ex_illegal, ALU_sel,
       Din1, Din2, ex_dest},
      {1'b0, 4'h0, 1'b0, 4'b0010, 32'd0, 32'd0, 5'd0});
  endtask

  task automatic check_reset(input string name);
    check(name,
      {ex_valid, ex_ctl, ex_illegal, ALU_sel, Din1, Din2,
       ex_store_data, ex_dest},
      '0);
  endtask

  initial begin
    #2;
    check_reset("reset_initial");
    #10 RST_n = 1'b1;
    @(posedge CLK); #1;

    // R sub: Din1=rt, Din2=rs
    issue(2'b10, 6'h00, 6'h22, 5'd0, 16'h0,
          5'd7, 32'd10, 5'd8, 32'd3, 5'd9, 4'b1000,
          4'b0011, 32'd3, 32'd10, 32'd3, 1'b0);
    // addi sign-extends
    issue(2'b11, 6'h08, 6'h00, 5'd0, 16'hFFFC,
          5'd1, 32'd8, 5'd2, 32'h55, 5'd2, 4'b1000,
          4'b0010, 32'd8, 32'hFFFFFFFC, 32'h55, 1'b0);
    // andi zero-extends
    issue(2'b11, 6'h0C, 6'h00, 5'd0, 16'hFFFC,
          5'd1, 32'd8, 5'd2, 32'h55, 5'd2, 4'b1000,
          4'b0000, 32'd8, 32'h0000FFFC, 32'h55, 1'b0);
    // ori
    issue(2'b11, 6'h0D, 6'h00, 5'd0, 16'h00F0,
          5'd1, 32'h1234, 5'd2, 32'h0, 5'd2, 4'b1000,
          4'b0001, 32'h1234, 32'hF0, 32'h0, 1'b0);
    // lw address add, negative offset
    issue(2'b00, 6'h23, 6'h00, 5'd0, 16'h8000,
          5'd3, 32'h100, 5'd4, 32'h7, 5'd4, 4'b1101,
          4'b0010, 32'h100, 32'hFFFF8000, 32'h7, 1'b0);
    // beq: Din1=rt, Din2=rs
    issue(2'b01, 6'h04, 6'h00, 5'd0, 16'h0010,
          5'd3, 32'd5, 5'd4, 32'd9, 5'd0, 4'b0000,
          4'b0011, 32'd9, 32'd5, 32'd9, 1'b0);
    // both sources match rs=5: EX/MEM wins
    fwd(5'd5, 1'b1, 32'h11, 5'd5, 1'b1, 32'h22);
    issue(2'b10, 6'h00, 6'h20, 5'd0, 16'h0,
          5'd5, 32'hAA, 5'd6, 32'h01, 5'd7, 4'b1000,
          4'b0010, 32'h11, 32'h01, 32'h01, 1'b0);
    // EX/MEM not writing: MEM/WB used
    fwd(5'd5, 1'b0, 32'h11, 5'd5, 1'b1, 32'h22);
    issue(2'b10, 6'h00, 6'h20, 5'd0, 16'h0,
          5'd5, 32'hAA, 5'd6, 32'h01, 5'd7, 4'b1000,
          4'b0010, 32'h22, 32'h01, 32'h01, 1'b0);
    // register 0 never forwarded
    fwd(5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22);
    issue(2'b10, 6'h00, 6'h20, 5'd0, 16'h0,
          5'd0, 32'h77, 5'd6, 32'h01, 5'd7, 4'b1000,
          4'b0010, 32'h77, 32'h01, 32'h01, 1'b0);
    // rt forwarded from MEM/WB on sub
    fwd(5'd3, 1'b1, 32'h11, 5'd6, 1'b1, 32'h40);
    issue(2'b10, 6'h00, 6'h22, 5'd0, 16'h0,
          5'd5, 32'h50, 5'd6, 32'h99, 5'd7, 4'b1000,
          4'b0011, 32'h40, 32'h50, 32'h40, 1'b0);
    // srav: shamt ignored, Din2=rs[4:0]
    issue(2'b10, 6'h00, 6'h07, 5'h1F, 16'h0,
          5'd4, 32'h24, 5'd3, 32'h80000000, 5'd7, 4'b1000,
          4'b1010, 32'h80000000, 32'd4, 32'h80000000, 1'b0);
    // sll by shamt
    issue(2'b10, 6'h00, 6'h00, 5'd3, 16'h0,
          5'd4, 32'h24, 5'd3, 32'h1, 5'd7, 4'b1000,
          4'b1001, 32'h1, 32'd3, 32'h1, 1'b0);
    // srlv with forwarded rs amount
    fwd(5'd4, 1'b1, 32'h3F, 5'd0, 1'b0, 32'h0);
    issue(2'b10, 6'h00, 6'h06, 5'd2, 16'h0,
          5'd4, 32'h999, 5'd3, 32'h80, 5'd7, 4'b1000,
          4'b1000, 32'h80, 32'h1F, 32'h80, 1'b0);
    // funct 0x27 illegal
    issue(2'b10, 6'h00, 6'h27, 5'd0, 16'h0,
          5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 4'b1000,
          4'b0010, 32'h5, 32'h6, 32'h6, 1'b1);
    // unsupported I opcode illegal, sext imm
    issue(2'b11, 6'h0F, 6'h00, 5'd0, 16'h0001,
          5'd1, 32'h5, 5'd2, 32'h6, 5'd2, 4'b1000,
          4'b0010, 32'h5, 32'h1, 32'h6, 1'b1);
    // xori zero-extends
    issue(2'b11, 6'h0E, 6'h00, 5'd0, 16'h8001,
          5'd1, 32'h5, 5'd2, 32'h6, 5'd2, 4'b1000,
          4'b0100, 32'h5, 32'h8001, 32'h6, 1'b0);

    // R xor, then hold 3 cycles while ID inputs change
    issue(2'b10, 6'h00, 6'h26, 5'd0, 16'h0,
          5'd10, 32'hF0F0, 5'd11, 32'h0FF0, 5'd12, 4'b1000,
          4'b0100, 32'hF0F0, 32'h0FF0, 32'h0FF0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_funct = 6'h22;
      id_dest = 5'd1 + 5'(i);
      id_ctl = 4'b0110;
      @(posedge CLK); #1;
      q.push_back(last_exp);
    end
    // flush and stall together: flush wins
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0; stall = 1'b0;
    check_bubble("flush_over_stall");

    // id_valid=0 on load behaves as flush
    issue(2'b10, 6'h00, 6'h25, 5'd0, 16'h0,
          5'd1, 32'h3, 5'd2, 32'hC, 5'd3, 4'b1000,
          4'b0001, 32'h3, 32'hC, 32'hC, 1'b0);
    id_valid = 1'b0;
    @(posedge CLK); #1;
    check_bubble("invalid_load");

    // async reset while stalled
    issue(2'b11, 6'h08, 6'h00, 5'd0, 16'h0004,
          5'd9, 32'h10, 5'd8, 32'h20, 5'd8, 4'b1000,
          4'b0010, 32'h10, 32'h4, 32'h20, 1'b0);
    stall = 1'b1;
    @(posedge CLK); #1;
    q.push_back(last_exp);
    #6 RST_n = 1'b0;
    #1 check_reset("reset_mid_stall");
    #1 RST_n = 1'b1;
    @(posedge CLK); #1;
    stall = 1'b0;
    id_valid = 1'b0;
    check_reset("reset_holds_in_stall");

    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
